// File: rtl/frame_buffer_ctrl.sv
`timescale 1ns/1ps
// frame_buffer_ctrl
//
// Double-buffered frame store controller. A frame is produced in the back bank:
// first every pixel is cleared to BG_COLOR (the z-buffer is cleared alongside
// through clear_z/clear_addr). The renderer then writes depth-tested pixels
// until draw_done. The banks are swapped on the next vsync. The display side
// reads the front bank through a 2-stage pipeline.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   frame_start  pulse: start a new frame (accepted in IDLE only)
//   draw_done    pulse: renderer finished (latched if it arrives during CLEAR)
//   pix_valid    pixel write strobe, honoured in DRAW only
//   pix_addr     pixel address x + y*SIZE
//   pix_color    pixel colour
//   vsync        pulse: display frame boundary, swaps banks from SWAP_WAIT
//   disp_addr    display read address
//   clear_z      z-buffer clear write enable (high during CLEAR only)
//   clear_addr   z-buffer clear address (0 outside CLEAR)
//   disp_color   front-bank colour, 2 cycles after disp_addr
//   ready_draw   high in DRAW
//   busy         high in any state but IDLE
//   frame_count  completed swaps, wraps at 2^16
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for frame_start
// CLEAR      | writing BG_COLOR to every back-bank pixel, clearing z-buffer
// DRAW       | accepting renderer pixel writes into the back bank
// SWAP_WAIT  | frame complete, waiting for vsync to swap the banks

module frame_buffer_ctrl #(
  parameter int                 SIZE     = 64,
  parameter int                 COLOR_W  = 10,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic                          draw_done,
  input  logic                          pix_valid,
  input  logic [$clog2(SIZE*SIZE)-1:0]  pix_addr,
  input  logic [COLOR_W-1:0]            pix_color,
  input  logic                          vsync,
  input  logic [$clog2(SIZE*SIZE)-1:0]  disp_addr,
  output logic                          clear_z,
  output logic [12:0]                   clear_addr,
  output logic [COLOR_W-1:0]            disp_color,
  output logic                          ready_draw,
  output logic                          busy,
  output logic [15:0]                   frame_count
);

  localparam int DEPTH = SIZE * SIZE;
  localparam int AW    = $clog2(DEPTH);

  // Pixel-address bound kept one bit wider so the range test stays meaningful
  // even when DEPTH is an exact power of two.
  localparam logic [AW:0]   DEPTH_X   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_CLEAR     = 2'd1;
  localparam logic [1:0] ST_DRAW      = 2'd2;
  localparam logic [1:0] ST_SWAP_WAIT = 2'd3;

  logic [1:0]         state;
  logic               front_sel;
  logic [AW-1:0]      clr_cnt;
  logic               done_latch;

  logic [COLOR_W-1:0] bank0 [DEPTH];
  logic [COLOR_W-1:0] bank1 [DEPTH];

  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic               pix_in_range;

  logic [AW-1:0]      rd_addr_q;
  logic               rd_sel_q;

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      front_sel   <= 1'b0;
      clr_cnt     <= '0;
      done_latch  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end

        ST_CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            // A draw_done in the final clear cycle counts as well; nothing was
            // drawn, so the (background-only) frame goes straight to the swap.
            state      <= (done_latch || draw_done) ? ST_SWAP_WAIT : ST_DRAW;
            done_latch <= 1'b0;
            clr_cnt    <= '0;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
            if (draw_done) begin
              done_latch <= 1'b1;
            end
          end
        end

        ST_DRAW: begin
          if (draw_done) begin
            state <= ST_SWAP_WAIT;
          end
        end

        ST_SWAP_WAIT: begin
          if (vsync) begin
            front_sel   <= ~front_sel;
            frame_count <= frame_count + 16'd1;
            state       <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state != ST_IDLE);
  assign ready_draw = (state == ST_DRAW);
  assign clear_z    = (state == ST_CLEAR);
  assign clear_addr = (state == ST_CLEAR) ? 13'(clr_cnt) : 13'd0;

  // ---------------------------------------------------------------------------
  // Back-bank write port: the clear sweep owns the port in CLEAR, the renderer
  // owns it in DRAW. Writes are suppressed during reset so an abandoned frame
  // does not get one extra pixel.
  // ---------------------------------------------------------------------------
  assign pix_in_range = ({1'b0, pix_addr} < DEPTH_X);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = pix_addr;
    wr_data = pix_color;
    if (!rst) begin
      if (state == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        wr_data = BG_COLOR;
      end else if (state == ST_DRAW && pix_valid && pix_in_range) begin
        wr_en = 1'b1;
      end
    end
  end

  // Bank storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en && front_sel) begin
      bank0[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !front_sel) begin
      bank1[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Display read pipeline. front_sel is captured together with the address, so
  // a read already in flight at a swap edge still completes from the old bank.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q  <= '0;
      rd_sel_q   <= 1'b0;
      disp_color <= '0;
    end else begin
      rd_addr_q  <= disp_addr;
      rd_sel_q   <= front_sel;
      disp_color <= rd_sel_q ? bank1[rd_addr_q] : bank0[rd_addr_q];
    end
  end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
`timescale 1ns/1ps
module tb_frame_buffer_ctrl;

  localparam int SIZE    = 64;
  localparam int COLOR_W = 10;
  localparam int DEPTH   = SIZE * SIZE;
  localparam int AW      = $clog2(DEPTH);
  localparam logic [COLOR_W-1:0] BG = '0;

  logic               clk = 1'b0;
  logic               rst;
  logic               frame_start;
  logic               draw_done;
  logic               pix_valid;
  logic [AW-1:0]      pix_addr;
  logic [COLOR_W-1:0] pix_color;
  logic               vsync;
  logic [AW-1:0]      disp_addr;
  logic               clear_z;
  logic [12:0]        clear_addr;
  logic [COLOR_W-1:0] disp_color;
  logic               ready_draw;
  logic               busy;
  logic [15:0]        frame_count;

  always #5 clk = ~clk;

  frame_buffer_ctrl #(.SIZE(SIZE), .COLOR_W(COLOR_W), .BG_COLOR(BG)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .draw_done(draw_done),
    .pix_valid(pix_valid), .pix_addr(pix_addr), .pix_color(pix_color),
    .vsync(vsync), .disp_addr(disp_addr), .clear_z(clear_z),
    .clear_addr(clear_addr), .disp_color(disp_color), .ready_draw(ready_draw),
    .busy(busy), .frame_count(frame_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a frame-level view with two plain pixel arrays, a phase,
  // a count of pixels cleared so far and a one-deep display read pipe.
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_CLEAR, M_DRAW, M_WAIT} mphase_t;

  mphase_t            m_ph;
  int                 m_clr;
  bit                 m_done;
  bit                 m_front;
  int                 m_count;
  logic [COLOR_W-1:0] m_bank  [2][DEPTH];
  bit                 m_known [2][DEPTH];
  int                 m_p_addr;
  bit                 m_p_sel;
  logic [COLOR_W-1:0] m_disp;
  bit                 m_disp_known;
  bit                 rand_disp;

  task automatic model_edge();
    logic [COLOR_W-1:0] rd;
    bit                 rdk;
    bit                 back;
    if (rst) begin
      m_ph = M_IDLE; m_clr = 0; m_done = 0; m_front = 0; m_count = 0;
      m_p_addr = 0; m_p_sel = 0; m_disp = '0; m_disp_known = 1;
      return;
    end
    rd  = m_bank[m_p_sel][m_p_addr];
    rdk = m_known[m_p_sel][m_p_addr];
    m_disp = rd;
    m_disp_known = rdk;
    m_p_addr = int'(disp_addr);
    m_p_sel  = m_front;
    back = !m_front;
    case (m_ph)
      M_IDLE: if (frame_start) begin m_ph = M_CLEAR; m_clr = 0; end
      M_CLEAR: begin
        m_bank[back][m_clr]  = BG;
        m_known[back][m_clr] = 1;
        if (draw_done) m_done = 1;
        if (m_clr == DEPTH - 1) begin
          m_ph = m_done ? M_WAIT : M_DRAW;
          m_done = 0;
        end else begin
          m_clr++;
        end
      end
      M_DRAW: begin
        if (pix_valid && int'(pix_addr) < DEPTH) begin
          m_bank[back][pix_addr]  = pix_color;
          m_known[back][pix_addr] = 1;
        end
        if (draw_done) m_ph = M_WAIT;
      end
      M_WAIT: if (vsync) begin
        m_front = !m_front;
        m_count = (m_count + 1) & 32'hFFFF;
        m_ph = M_IDLE;
      end
      default: m_ph = M_IDLE;
    endcase
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("busy", 32'(busy), 32'(m_ph != M_IDLE));
    chk("ready_draw", 32'(ready_draw), 32'(m_ph == M_DRAW));
    chk("clear_z", 32'(clear_z), 32'(m_ph == M_CLEAR));
    chk("clear_addr", 32'(clear_addr), (m_ph == M_CLEAR) ? 32'(m_clr) : 32'd0);
    chk("frame_count", 32'(frame_count), 32'(m_count));
    if (m_disp_known) chk("disp_color", 32'(disp_color), 32'(m_disp));
    frame_start = 1'b0;
    draw_done   = 1'b0;
    vsync       = 1'b0;
    pix_valid   = 1'b0;
    if (rand_disp) disp_addr = AW'($urandom_range(0, DEPTH - 1));
  endtask

  task automatic read_check(input int addr, input logic [COLOR_W-1:0] exp, input string name);
    disp_addr = AW'(addr);
    tick();
    tick();
    chk(name, 32'(disp_color), 32'(exp));
  endtask

  // Walks the clear sweep, checking the address order independently of the
  // model. Optional events keyed on the clear cycle index.
  task automatic run_clear(input int dd_at, input int pv_lo, input int pv_hi,
                           input int rst_at, output int n);
    n = 0;
    while (clear_z && n < DEPTH + 8) begin
      chk("clear_addr_order", 32'(clear_addr), 32'(n));
      if (n == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        return;
      end
      if (n == dd_at) draw_done = 1'b1;
      if (n >= pv_lo && n <= pv_hi) begin
        pix_valid = 1'b1; pix_addr = AW'(5); pix_color = 10'h155;
      end
      tick();
      n++;
    end
  endtask

  typedef struct {
    int                 addr;
    logic [COLOR_W-1:0] exp;
  } rd_vec_t;

  rd_vec_t rd_tbl [6];

  initial begin
    int  n;
    bit  saw_ready;

    rd_tbl[0] = '{addr: 65,   exp: 10'h3FF};
    rd_tbl[1] = '{addr: 64,   exp: BG};
    rd_tbl[2] = '{addr: 300,  exp: 10'h2AA};
    rd_tbl[3] = '{addr: 0,    exp: BG};
    rd_tbl[4] = '{addr: 4095, exp: BG};
    rd_tbl[5] = '{addr: 66,   exp: BG};

    rst = 1'b1; frame_start = 0; draw_done = 0; pix_valid = 0; vsync = 0;
    pix_addr = '0; pix_color = '0; disp_addr = '0; rand_disp = 1'b1;

    // Reset state
    tick();
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_frame_count", 32'(frame_count), 32'd0);
    chk("reset_disp_color", 32'(disp_color), 32'd0);
    rst = 1'b0;

    // Reset in the middle of a clear abandons the frame
    frame_start = 1'b1;
    tick();
    run_clear(-1, -1, -1, 2000, n);
    chk("rst_mid_clear_at", 32'(n), 32'd2000);
    chk("rst_mid_clear_z", 32'(clear_z), 32'd0);
    chk("rst_mid_clear_busy", 32'(busy), 32'd0);
    chk("rst_mid_clear_count", 32'(frame_count), 32'd0);

    // Full clear sweep
    frame_start = 1'b1;
    tick();
    run_clear(-1, -1, -1, -1, n);
    chk("clear_len", 32'(n), 32'(DEPTH));
    chk("ready_after_clear", 32'(ready_draw), 32'd1);

    // Draw, finish, swap
    pix_valid = 1'b1; pix_addr = AW'(65); pix_color = 10'h3FF;
    tick();
    for (int i = 0; i < 20; i++) begin
      pix_valid = 1'b1;
      pix_addr  = AW'($urandom_range(400, 4000));
      pix_color = COLOR_W'($urandom);
      tick();
    end
    pix_valid = 1'b1; pix_addr = AW'(300); pix_color = 10'h2AA; draw_done = 1'b1;
    tick();
    chk("ready_after_done", 32'(ready_draw), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("no_swap_without_vsync", 32'(frame_count), 32'd0);
    vsync = 1'b1;
    tick();
    chk("frame_count_1", 32'(frame_count), 32'd1);
    chk("idle_after_swap", 32'(busy), 32'd0);

    // Table of display reads, pipelined back to back
    rand_disp = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) disp_addr = AW'(rd_tbl[i].addr);
      tick();
      if (i >= 1) chk("disp_table", 32'(disp_color), 32'(rd_tbl[i-1].exp));
    end
    // Sweep every front pixel; the model compares each read
    for (int a = 0; a < DEPTH + 2; a++) begin
      if (a < DEPTH) disp_addr = AW'(a);
      tick();
    end
    rand_disp = 1'b1;

    // Pixel strobes outside DRAW; draw_done during clear skips DRAW
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1; pix_addr = AW'(5); pix_color = 10'h155;
      tick();
    end
    read_check(5, BG, "idle_pix_front5");
    frame_start = 1'b1;
    tick();
    run_clear(100, 10, 20, -1, n);
    chk("clear_len_dd", 32'(n), 32'(DEPTH));
    chk("dd_skip_draw_ready", 32'(ready_draw), 32'd0);
    chk("dd_swap_wait_busy", 32'(busy), 32'd1);
    saw_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pix_valid = 1'b1; pix_addr = AW'(5); pix_color = 10'h155;
      tick();
      saw_ready |= ready_draw;
    end
    chk("ready_never", 32'(saw_ready), 32'd0);
    vsync = 1'b1;
    tick();
    chk("frame_count_2", 32'(frame_count), 32'd2);
    read_check(5, BG, "dropped_pix_new_front5");

    // vsync together with draw_done must not swap
    frame_start = 1'b1;
    tick();
    run_clear(-1, -1, -1, -1, n);
    for (int i = 0; i < 50; i++) begin
      pix_valid = 1'($urandom_range(0, 1));
      pix_addr  = AW'($urandom_range(0, DEPTH - 1));
      pix_color = COLOR_W'($urandom);
      tick();
    end
    draw_done = 1'b1; vsync = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    chk("vsync_with_done_noswap", 32'(frame_count), 32'd2);
    chk("vsync_with_done_busy", 32'(busy), 32'd1);
    vsync = 1'b1;
    tick();
    chk("frame_count_3", 32'(frame_count), 32'd3);

    // Random traffic on every input against the model
    for (int c = 0; c < 20000; c++) begin
      rst         = ($urandom_range(0, 9999) == 0);
      frame_start = ($urandom_range(0, 39) == 0);
      draw_done   = ($urandom_range(0, 299) == 0);
      vsync       = ($urandom_range(0, 15) == 0);
      pix_valid   = 1'($urandom_range(0, 1));
      pix_addr    = AW'($urandom_range(0, DEPTH - 1));
      pix_color   = COLOR_W'($urandom);
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_buffer_ctrl.md
FRAME_BUFFER_CTRL -- requirements
Module: frame_buffer_ctrl

Interface
REQ-001 Parameter: SIZE, 64, frame edge length in pixels; frame holds SIZE*SIZE pixels.
REQ-002 Parameter: COLOR_W, 10, pixel colour width.
REQ-003 Parameter: BG_COLOR, 0, colour written to every back-buffer pixel during clear.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 frame_start  in  1  single-cycle request to begin a new frame (clear, then draw).
REQ-007 draw_done  in  1  single-cycle pulse; renderer has issued its last pixel.
REQ-008 pix_valid  in  1  depth-tested pixel write strobe from the z-buffer stage.
REQ-009 pix_addr  in  $clog2(SIZE*SIZE)  pixel address, x + y*SIZE.
REQ-010 pix_color  in  COLOR_W  pixel colour.
REQ-011 vsync  in  1  single-cycle display frame-boundary pulse.
REQ-012 disp_addr  in  $clog2(SIZE*SIZE)  display read address.
REQ-013 clear_z  out  1  drives the z-buffer clear write enable.
REQ-014 clear_addr  out  13  drives the z-buffer clear address.
REQ-015 disp_color  out  COLOR_W  front-buffer colour at disp_addr.
REQ-016 ready_draw  out  1  high while pixel writes are accepted.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 frame_count  out  16  number of completed buffer swaps, wraps at 2^16.

Function
REQ-019 Two banks of SIZE*SIZE x COLOR_W storage; front_sel (1 bit) selects the display bank, the other bank is the back (write) bank.
REQ-020 States: IDLE, CLEAR, DRAW, SWAP_WAIT.
REQ-021 IDLE: frame_start -> CLEAR with clear counter = 0; frame_start in any other state ignored.
REQ-022 CLEAR: each cycle write BG_COLOR to back bank at counter, clear_z = 1, clear_addr = counter zero-extended; counter increments by 1.
REQ-023 CLEAR exits after the cycle writing address SIZE*SIZE-1 (exactly SIZE*SIZE cycles with clear_z high); next state DRAW, or SWAP_WAIT if draw_done was latched during CLEAR.
REQ-024 clear_z is 0 and clear_addr is 0 in every state except CLEAR.
REQ-025 draw_done arriving during CLEAR is latched; the latch is cleared on CLEAR exit; draw_done in IDLE or SWAP_WAIT ignored.
REQ-026 ready_draw = 1 only in DRAW.
REQ-027 DRAW: pix_valid=1 writes pix_color to back bank at pix_addr in the same edge; pix_valid outside DRAW is dropped; pix_addr >= SIZE*SIZE is dropped.
REQ-028 DRAW: draw_done -> SWAP_WAIT; pix_valid in the same cycle as draw_done is still written.
REQ-029 SWAP_WAIT: on vsync, toggle front_sel, increment frame_count, go to IDLE; vsync in the same cycle that SWAP_WAIT is entered does not swap.
REQ-030 vsync in any other state has no effect.
REQ-031 Display read: disp_addr and front_sel registered in cycle N, bank read in N+1, disp_color valid in N+2 (2-cycle latency, fully pipelined, one read per cycle).
REQ-032 A swap takes effect for display reads whose address is registered after the swap edge; in-flight reads complete from the old bank.
REQ-033 busy = (state != IDLE).

Reset
REQ-034 rst: state IDLE, front_sel 0, clear counter 0, draw_done latch 0, frame_count 0, clear_z 0, clear_addr 0, disp_color 0, read pipeline cleared.
REQ-035 Bank contents are not reset; rst mid-CLEAR or mid-DRAW abandons the frame, no swap occurs.

Verification
REQ-036 rst, frame_start -> clear_z high exactly 4096 cycles, clear_addr 0..4095 in order, then ready_draw=1; back bank all BG_COLOR.
REQ-037 DRAW, write addr 65 colour 10'h3FF, draw_done, vsync -> frame_count=1; disp_addr=65 returns 10'h3FF two cycles later, addr 64 returns BG_COLOR.
REQ-038 draw_done pulsed at clear cycle 100 -> after clear, state SWAP_WAIT directly, ready_draw never asserted; next vsync swaps.
REQ-039 pix_valid during CLEAR and IDLE at addr 5 colour 10'h155 -> addr 5 in both banks unchanged.
REQ-040 Continuous display reads across a swap edge -> reads registered before the edge return old-bank data, after return new-bank data, no bubble.
REQ-041 vsync same cycle as draw_done -> no swap; swap on following vsync; rst asserted mid-CLEAR at cycle 2000 -> clear_z 0 next cycle, state IDLE, frame_count unchanged.
